// File: rtl/ps2_input_router_pkg.sv
// Shared constants, parser state type and event-code helper for the PS/2 input router.
package ps2_router_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_E1  = 8'hE1;

  localparam int MAP_ENTRY_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parser_state_t;

  // Event codes are 1-based so that 0 can mean "no event" on an empty FIFO.
  function automatic logic [7:0] event_code(input logic [2:0] idx);
    return {5'b0, idx + 3'd1};
  endfunction

endpackage

// File: rtl/ps2_input_router_if.sv
// Per-player key event stream: show-ahead valid/code with consumer ready.
interface ps2_input_router_if #(
  parameter int NUM_PLAYERS = 2
);

  logic [NUM_PLAYERS-1:0]   evt_valid;
  logic [NUM_PLAYERS*8-1:0] evt_code;
  logic [NUM_PLAYERS-1:0]   evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/ps2_input_router_event_fifo.sv
// Show-ahead event FIFO with a sticky overflow flag; a full FIFO still accepts a push when popped in the same cycle.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign valid   = (count != '0);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_input_router.sv
// Parses the PS/2 byte stream (E0/F0 prefixes), matches makes/breaks against a runtime key map
// and feeds per-player edge-only event FIFOs, held-key state and a game-reset pulse.
module ps2_input_router
  import ps2_router_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int KEYS_PER_PLAYER = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [7:0]                                        ps2_key_data,
  input  logic                                              ps2_key_pressed,
  input  logic [NUM_PLAYERS*KEYS_PER_PLAYER*MAP_ENTRY_W-1:0] key_map,
  input  logic [7:0]                                        reset_code,
  ps2_input_router_if.master                                evt,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0]            held,
  output logic                                              game_reset_req,
  output logic [NUM_PLAYERS-1:0]                            overflow
);

  localparam int K = KEYS_PER_PLAYER;

  parser_state_t state;
  parser_state_t state_next;
  logic          make_evt;
  logic          brk_evt;
  logic          cur_ext;

  assign cur_ext = (state == EXT) || (state == EXT_BRK);

  always_comb begin
    state_next = state;
    make_evt   = 1'b0;
    brk_evt    = 1'b0;
    if (ps2_key_pressed) begin
      case (state)
        IDLE: begin
          if (ps2_key_data == PS2_EXT)      state_next = EXT;
          else if (ps2_key_data == PS2_BRK) state_next = BRK;
          else if (ps2_key_data != PS2_E1)  make_evt   = 1'b1;
        end
        EXT: begin
          if (ps2_key_data == PS2_BRK) begin
            state_next = EXT_BRK;
          end else if (ps2_key_data != PS2_EXT) begin
            make_evt   = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          brk_evt    = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  logic [NUM_PLAYERS-1:0]      hit;
  logic [NUM_PLAYERS-1:0]      was_held;
  logic [NUM_PLAYERS-1:0]      push;
  logic [NUM_PLAYERS-1:0][2:0] hit_idx;

  // Descending scan so the lowest matching key index wins.
  always_comb begin
    hit      = '0;
    hit_idx  = '0;
    was_held = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int k = K - 1; k >= 0; k--) begin
        if ((ps2_key_data != 8'h00) &&
            (key_map[(p*K + k)*MAP_ENTRY_W +: MAP_ENTRY_W] == {cur_ext, ps2_key_data})) begin
          hit[p]      = 1'b1;
          hit_idx[p]  = 3'(k);
          was_held[p] = held[p*K + k];
        end
      end
    end
  end

  assign push = hit & ~was_held & {NUM_PLAYERS{make_evt}};

  always_ff @(posedge clock) begin
    if (reset) begin
      held <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int k = 0; k < K; k++) begin
          if (hit[p] && (hit_idx[p] == 3'(k))) begin
            if (make_evt)     held[p*K + k] <= 1'b1;
            else if (brk_evt) held[p*K + k] <= 1'b0;
          end
        end
      end
    end
  end

  // Fires on every non-extended make of the reset code, repeats included.
  always_ff @(posedge clock) begin
    if (reset) game_reset_req <= 1'b0;
    else       game_reset_req <= make_evt && !cur_ext && (ps2_key_data == reset_code);
  end

  logic [NUM_PLAYERS-1:0]      fifo_valid;
  logic [NUM_PLAYERS*8-1:0]    fifo_code;
  logic [NUM_PLAYERS-1:0][7:0] push_code;

  assign evt.evt_valid = fifo_valid;
  assign evt.evt_code  = fifo_code;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign push_code[p] = event_code(hit_idx[p]);

    event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push[p]),
      .push_data (push_code[p]),
      .pop       (evt.evt_ready[p]),
      .valid     (fifo_valid[p]),
      .head      (fifo_code[p*8 +: 8]),
      .overflow  (overflow[p])
    );
  end

endmodule

// File: tb/tb_ps2_input_router.sv
// Randomised and directed bench: a queue-based reference model built from the key/event rules feeds a negedge scoreboard monitor.
module tb_ps2_input_router;

  localparam int NP = 2;
  localparam int K  = 4;
  localparam int D  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        ps2_key_data;
  logic              ps2_key_pressed;
  logic [NP*K*9-1:0] key_map;
  logic [7:0]        reset_code;
  logic [NP*K-1:0]   held;
  logic              game_reset_req;
  logic [NP-1:0]     overflow;

  ps2_input_router_if #(.NUM_PLAYERS(NP)) evt_bus ();

  ps2_input_router #(
    .NUM_PLAYERS     (NP),
    .KEYS_PER_PLAYER (K),
    .FIFO_DEPTH      (D)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .key_map         (key_map),
    .reset_code      (reset_code),
    .evt             (evt_bus),
    .held            (held),
    .game_reset_req  (game_reset_req),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  logic [7:0] exp_q [NP][$];
  bit         mheld [NP][K];
  bit         movf  [NP];
  bit         mrst;
  bit         pend_ext;
  bit         pend_brk;
  bit         run_checks = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] pool [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};

  function automatic int find_key(input int p, input bit ext, input logic [7:0] code);
    for (int k = 0; k < K; k++) begin
      if (code != 8'h00 && key_map[(p*K + k)*9 +: 9] == {ext, code}) return k;
    end
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (pend_brk) begin
      for (int p = 0; p < NP; p++) begin
        k = find_key(p, pend_ext, b);
        if (k >= 0) mheld[p][k] = 1'b0;
      end
      pend_brk = 1'b0;
      pend_ext = 1'b0;
    end else if (b == 8'hE0) begin
      pend_ext = 1'b1;
    end else if (b == 8'hF0) begin
      pend_brk = 1'b1;
    end else if (b == 8'hE1 && !pend_ext) begin
    end else begin
      if (!pend_ext && b == reset_code) mrst = 1'b1;
      for (int p = 0; p < NP; p++) begin
        k = find_key(p, pend_ext, b);
        if (k >= 0 && !mheld[p][k]) begin
          mheld[p][k] = 1'b1;
          if (exp_q[p].size() < D) exp_q[p].push_back(8'(k + 1));
          else                     movf[p] = 1'b1;
        end
      end
      pend_ext = 1'b0;
    end
  endtask

  // Reference model advances on the same edge the DUT samples its inputs.
  always @(posedge clock) begin : model
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        exp_q[p].delete();
        movf[p] = 1'b0;
        for (int k = 0; k < K; k++) mheld[p][k] = 1'b0;
      end
      mrst     = 1'b0;
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end else begin
      mrst = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (evt_bus.evt_ready[p] && exp_q[p].size() > 0) void'(exp_q[p].pop_front());
      end
      if (ps2_key_pressed) model_byte(ps2_key_data);
    end
  end

  task automatic check_output(input string name, input int p, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s p%0d actual %0h required %0h at %0t", name, p, act, req, $time);
    end
  endtask

  always @(negedge clock) begin : monitor
    logic [NP*K-1:0] exp_held;
    logic [NP-1:0]   exp_ovf;
    if (run_checks) begin
      for (int p = 0; p < NP; p++) begin
        check_output("evt_valid", p, 32'(evt_bus.evt_valid[p]), 32'(exp_q[p].size() > 0));
        if (exp_q[p].size() > 0) check_output("evt_code", p, 32'(evt_bus.evt_code[p*8 +: 8]), 32'(exp_q[p][0]));
        else                     check_output("evt_code_empty", p, 32'(evt_bus.evt_code[p*8 +: 8]), 32'h0);
        exp_ovf[p] = movf[p];
        for (int k = 0; k < K; k++) exp_held[p*K + k] = mheld[p][k];
      end
      check_output("held", 0, 32'(held), 32'(exp_held));
      check_output("overflow", 0, 32'(overflow), 32'(exp_ovf));
      check_output("game_reset_req", 0, 32'(game_reset_req), 32'(mrst));
    end
  end

  task automatic apply_stimulus(input logic stb, input logic [7:0] b, input logic [NP-1:0] rdy);
    @(negedge clock);
    ps2_key_pressed   = stb;
    ps2_key_data      = b;
    evt_bus.evt_ready = rdy;
  endtask

  task automatic idle(input int n, input logic [NP-1:0] rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, rdy);
  endtask

  // The strobe issued alongside reset must be ignored.
  task automatic do_reset();
    @(negedge clock);
    reset           = 1'b1;
    ps2_key_pressed = 1'b1;
    ps2_key_data    = 8'h1D;
    @(negedge clock);
    reset           = 1'b0;
    ps2_key_pressed = 1'b0;
  endtask

  task automatic set_entry(input int p, input int k, input logic ext, input logic [7:0] code);
    key_map[(p*K + k)*9 +: 9] = {ext, code};
  endtask

  task automatic default_map();
    for (int k = 0; k < K; k++) begin
      set_entry(0, k, 1'b0, pool[k]);
      set_entry(1, k, 1'b1, pool[k + 4]);
    end
  endtask

  task automatic random_map();
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < K; k++) begin
        if ($urandom_range(3) == 0) set_entry(p, k, 1'b0, 8'h00);
        else set_entry(p, k, 1'($urandom_range(1)), pool[$urandom_range(7)]);
      end
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(99);
    if (r < 40) return pool[$urandom_range(7)];
    if (r < 55) return 8'hE0;
    if (r < 70) return 8'hF0;
    if (r < 75) return 8'hE1;
    if (r < 80) return 8'h2D;
    return 8'($urandom);
  endfunction

  initial begin
    reset             = 1'b1;
    ps2_key_pressed   = 1'b0;
    ps2_key_data      = 8'h00;
    evt_bus.evt_ready = '0;
    reset_code        = 8'h2D;
    key_map           = '0;
    default_map();
    do_reset();
    run_checks = 1'b1;

    // Make/break of P0 key 0; P1 must stay silent.
    apply_stimulus(1'b1, 8'h1D, 2'b11);
    apply_stimulus(1'b1, 8'hF0, 2'b11);
    apply_stimulus(1'b1, 8'h1D, 2'b11);
    idle(3, 2'b11);

    // Extended make/break for P1, then non-extended 6B which must not match.
    apply_stimulus(1'b1, 8'hE0, 2'b11);
    apply_stimulus(1'b1, 8'h6B, 2'b11);
    apply_stimulus(1'b1, 8'hE0, 2'b11);
    apply_stimulus(1'b1, 8'hF0, 2'b11);
    apply_stimulus(1'b1, 8'h6B, 2'b11);
    apply_stimulus(1'b1, 8'h6B, 2'b11);
    apply_stimulus(1'b1, 8'hF0, 2'b11);
    apply_stimulus(1'b1, 8'h6B, 2'b11);
    idle(3, 2'b11);

    // Typematic repeats produce a single event.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'h23, 2'b11);
    apply_stimulus(1'b1, 8'hF0, 2'b11);
    apply_stimulus(1'b1, 8'h23, 2'b11);
    idle(3, 2'b11);

    // Five makes into a depth-4 FIFO with no consumer, then drain.
    do_reset();
    apply_stimulus(1'b1, 8'h1D, 2'b00);
    apply_stimulus(1'b1, 8'h1C, 2'b00);
    apply_stimulus(1'b1, 8'h1B, 2'b00);
    apply_stimulus(1'b1, 8'h23, 2'b00);
    apply_stimulus(1'b1, 8'hF0, 2'b00);
    apply_stimulus(1'b1, 8'h1D, 2'b00);
    apply_stimulus(1'b1, 8'h1D, 2'b00);
    idle(2, 2'b00);
    idle(6, 2'b11);

    // Full FIFO: push and pop together keeps occupancy and no overflow.
    do_reset();
    apply_stimulus(1'b1, 8'h1D, 2'b00);
    apply_stimulus(1'b1, 8'h1C, 2'b00);
    apply_stimulus(1'b1, 8'h1B, 2'b00);
    apply_stimulus(1'b1, 8'h23, 2'b00);
    apply_stimulus(1'b1, 8'hF0, 2'b00);
    apply_stimulus(1'b1, 8'h1D, 2'b00);
    apply_stimulus(1'b1, 8'h1D, 2'b01);
    idle(2, 2'b00);
    idle(6, 2'b11);

    // Game reset pulses, and a reset that discards a pending E0.
    apply_stimulus(1'b1, 8'h2D, 2'b11);
    idle(2, 2'b11);
    apply_stimulus(1'b1, 8'h2D, 2'b11);
    apply_stimulus(1'b1, 8'h2D, 2'b11);
    idle(2, 2'b11);
    apply_stimulus(1'b1, 8'hE0, 2'b11);
    do_reset();
    apply_stimulus(1'b1, 8'h75, 2'b11);
    idle(3, 2'b11);

    for (int i = 0; i < 3000; i++) begin
      logic [NP-1:0] rdy;
      rdy = ((i / 200) % 2 == 1) ? NP'($urandom) : (NP'($urandom) & NP'($urandom));
      if (i % 600 == 599) begin
        do_reset();
      end else begin
        if (i % 700 == 350) random_map();
        apply_stimulus(1'($urandom_range(9) < 7), rand_byte(), rdy);
      end
    end

    default_map();
    idle(10, 2'b11);
    run_checks = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
